f_fetch_pc: RTL and testbench

Fetch-stage PC register, next-PC selector and F/D pipeline register for the five-stage MIPS pipeline. It sits directly upstream of the D-stage comparator. It consumes that comparator's branch outcome together with the D-stage jump/branch decode to redirect fetch. It latches the fetched word and its PC into D every non-stalled cycle. Branches use one architectural delay slot, so no flush logic exists.

---
 rtl/npc_pkg.sv | 26 ++
 rtl/npc_calc.sv | 39 +++
 rtl/f_fetch_pc.sv | 59 +++++
 tb/tb_f_fetch_pc.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared encodings and constants for the fetch-stage next-PC logic.
package npc_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned IMM_W  = 16;
    localparam int unsigned IDX_W  = 26;

    typedef enum logic [OP_W-1:0] {
        NPC_PC4    = 3'd0,
        NPC_BRANCH = 3'd1,
        NPC_J      = 3'd2,
        NPC_JR     = 3'd3
    } npc_op_e;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_3000;
    localparam logic [XLEN-1:0] NOP              = 32'h0000_0000;

    // F/D pipeline register payload
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fd_reg_t;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC target computation and selection.
module npc_calc
    import npc_pkg::*;
(
    input  logic [XLEN-1:0]  f_pc,
    input  logic [XLEN-1:0]  d_pc,
    input  logic             d_valid,
    input  logic [OP_W-1:0]  d_npc_op,
    input  logic             d_cmp_suc,
    input  logic [IMM_W-1:0] d_imm16,
    input  logic [IDX_W-1:0] d_index26,
    input  logic [XLEN-1:0]  d_rs_val,
    output logic [XLEN-1:0]  npc_c
);

    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] br_off;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] j_tgt;

    assign pc4    = f_pc + 32'd4;
    assign br_off = {{(XLEN-IMM_W-2){d_imm16[IMM_W-1]}}, d_imm16, 2'b00};
    assign br_tgt = d_pc + 32'd4 + br_off;
    assign j_tgt  = {d_pc[31:28], d_index26, 2'b00};

    // Reserved encodings and an empty D stage fall through to sequential fetch
    always_comb begin
        npc_c = pc4;
        if (d_valid) begin
            case (d_npc_op)
                NPC_BRANCH: npc_c = d_cmp_suc ? br_tgt : pc4;
                NPC_J:      npc_c = j_tgt;
                NPC_JR:     npc_c = d_rs_val;
                default:    npc_c = pc4;
            endcase
        end
    end

endmodule

// File: rtl/f_fetch_pc.sv
// Fetch-stage PC register, F/D pipeline register and fetch counter.
module f_fetch_pc
    import npc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [XLEN-1:0]  im_instr,
    input  logic [OP_W-1:0]  d_npc_op,
    input  logic             d_cmp_suc,
    input  logic [IMM_W-1:0] d_imm16,
    input  logic [IDX_W-1:0] d_index26,
    input  logic [XLEN-1:0]  d_rs_val,
    output logic [XLEN-1:0]  f_pc,
    output logic             f_pc_misalign,
    output logic [XLEN-1:0]  d_instr,
    output logic [XLEN-1:0]  d_pc,
    output logic [XLEN-1:0]  d_pc8,
    output logic             d_valid,
    output logic [XLEN-1:0]  fetch_cnt
);

    fd_reg_t         fd_q;
    logic [XLEN-1:0] npc;

    npc_calc u_npc_calc (
        .f_pc      (f_pc),
        .d_pc      (fd_q.pc),
        .d_valid   (fd_q.valid),
        .d_npc_op  (d_npc_op),
        .d_cmp_suc (d_cmp_suc),
        .d_imm16   (d_imm16),
        .d_index26 (d_index26),
        .d_rs_val  (d_rs_val),
        .npc_c     (npc)
    );

    // A stalled cycle drops any redirect; it is recomputed once the stall lifts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_pc      <= RESET_PC;
            fd_q      <= '{valid: 1'b0, instr: NOP, pc: '0};
            fetch_cnt <= '0;
        end else if (!stall) begin
            f_pc      <= npc;
            fd_q      <= '{valid: 1'b1, instr: im_instr, pc: f_pc};
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

    assign d_instr       = fd_q.instr;
    assign d_pc          = fd_q.pc;
    assign d_valid       = fd_q.valid;
    assign d_pc8         = fd_q.pc + 32'd8;
    assign f_pc_misalign = (f_pc[1:0] != 2'b00);

endmodule

// File: tb/tb_f_fetch_pc.sv
// Directed self-checking bench for the fetch-stage PC and F/D register.
module tb_f_fetch_pc;
    import npc_pkg::*;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] im_instr;
    logic [2:0]  d_npc_op;
    logic        d_cmp_suc;
    logic [15:0] d_imm16;
    logic [25:0] d_index26;
    logic [31:0] d_rs_val;
    logic [31:0] f_pc;
    logic        f_pc_misalign;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [31:0] d_pc8;
    logic        d_valid;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int passed = 0;

    f_fetch_pc #(.RESET_PC(32'h0000_3000)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .im_instr      (im_instr),
        .d_npc_op      (d_npc_op),
        .d_cmp_suc     (d_cmp_suc),
        .d_imm16       (d_imm16),
        .d_index26     (d_index26),
        .d_rs_val      (d_rs_val),
        .f_pc          (f_pc),
        .f_pc_misalign (f_pc_misalign),
        .d_instr       (d_instr),
        .d_pc          (d_pc),
        .d_pc8         (d_pc8),
        .d_valid       (d_valid),
        .fetch_cnt     (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory stand-in: a distinct word per address
    function automatic logic [31:0] imw(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    assign im_instr = imw(f_pc);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] op);
        d_npc_op = op;
    endtask

    // Async reset pulse placed between edges, then released before the next edge
    task automatic restart();
        reset = 1'b0;
        set_op(NPC_PC4);
        stall = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; set_op(NPC_J);
        d_cmp_suc = 1'b0; d_imm16 = '0; d_index26 = 26'h3FF_FFFF; d_rs_val = '0;
        repeat (2) step();
        checks++; if (f_pc !== 32'h3000) $display("FAIL rst_f_pc got %h want %h", f_pc, 32'h3000); else passed++;
        checks++; if (d_instr !== 32'h0) $display("FAIL rst_d_instr got %h want %h", d_instr, 32'h0); else passed++;
        checks++; if (d_pc !== 32'h0) $display("FAIL rst_d_pc got %h want %h", d_pc, 32'h0); else passed++;
        checks++; if (d_valid !== 1'b0) $display("FAIL rst_d_valid got %b want 0", d_valid); else passed++;
        checks++; if (fetch_cnt !== 32'h0) $display("FAIL rst_cnt got %h want 0", fetch_cnt); else passed++;
        checks++; if (d_pc8 !== 32'h8) $display("FAIL rst_d_pc8 got %h want %h", d_pc8, 32'h8); else passed++;
        checks++; if (f_pc_misalign !== 1'b0) $display("FAIL rst_misalign got %b want 0", f_pc_misalign); else passed++;
        reset = 1'b1;
        // d_valid is 0 here, so the J request must be ignored
        step();
        checks++; if (f_pc !== 32'h3004) $display("FAIL seq1_f_pc got %h want %h", f_pc, 32'h3004); else passed++;
        checks++; if (d_pc !== 32'h3000) $display("FAIL seq1_d_pc got %h want %h", d_pc, 32'h3000); else passed++;
        checks++; if (d_valid !== 1'b1) $display("FAIL seq1_d_valid got %b want 1", d_valid); else passed++;
        set_op(NPC_PC4);
        step();
        checks++; if (f_pc !== 32'h3008) $display("FAIL seq2_f_pc got %h want %h", f_pc, 32'h3008); else passed++;
        checks++; if (d_pc !== 32'h3004) $display("FAIL seq2_d_pc got %h want %h", d_pc, 32'h3004); else passed++;
        step();
        checks++; if (f_pc !== 32'h300C) $display("FAIL seq3_f_pc got %h want %h", f_pc, 32'h300C); else passed++;
        checks++; if (d_pc !== 32'h3008) $display("FAIL seq3_d_pc got %h want %h", d_pc, 32'h3008); else passed++;
        checks++; if (d_instr !== imw(32'h3008)) $display("FAIL seq3_d_instr got %h want %h", d_instr, imw(32'h3008)); else passed++;
        checks++; if (fetch_cnt !== 32'd3) $display("FAIL seq3_cnt got %0d want 3", fetch_cnt); else passed++;
    endtask

    // Entry: d_pc=3008, f_pc=300C
    task automatic test_branch();
        set_op(NPC_BRANCH); d_imm16 = 16'hFFFE; d_cmp_suc = 1'b1;
        step();
        checks++; if (f_pc !== 32'h3004) $display("FAIL br_taken_f_pc got %h want %h", f_pc, 32'h3004); else passed++;
        checks++; if (d_pc !== 32'h300C) $display("FAIL br_slot_d_pc got %h want %h", d_pc, 32'h300C); else passed++;
        checks++; if (d_instr !== imw(32'h300C)) $display("FAIL br_slot_d_instr got %h want %h", d_instr, imw(32'h300C)); else passed++;
        checks++; if (fetch_cnt !== 32'd4) $display("FAIL br_cnt got %0d want 4", fetch_cnt); else passed++;
        set_op(NPC_PC4);
        repeat (2) step();
        checks++; if (d_pc !== 32'h3008) $display("FAIL brnt_setup_d_pc got %h want %h", d_pc, 32'h3008); else passed++;
        set_op(NPC_BRANCH); d_cmp_suc = 1'b0;
        step();
        checks++; if (f_pc !== 32'h3010) $display("FAIL br_not_taken_f_pc got %h want %h", f_pc, 32'h3010); else passed++;
        checks++; if (fetch_cnt !== 32'd7) $display("FAIL brnt_cnt got %0d want 7", fetch_cnt); else passed++;
        set_op(NPC_PC4);
    endtask

    task automatic test_jump();
        restart();
        step();
        checks++; if (d_pc !== 32'h3000) $display("FAIL j_setup_d_pc got %h want %h", d_pc, 32'h3000); else passed++;
        set_op(NPC_J); d_index26 = 26'h000_0C10;
        step();
        checks++; if (f_pc !== 32'h3040) $display("FAIL j_f_pc got %h want %h", f_pc, 32'h3040); else passed++;
        set_op(NPC_JR); d_rs_val = 32'h0000_3002;
        step();
        checks++; if (f_pc !== 32'h3002) $display("FAIL jr_f_pc got %h want %h", f_pc, 32'h3002); else passed++;
        checks++; if (f_pc_misalign !== 1'b1) $display("FAIL jr_misalign got %b want 1", f_pc_misalign); else passed++;
        checks++; if (d_pc8 !== 32'h3048) $display("FAIL jr_d_pc8 got %h want %h", d_pc8, 32'h3048); else passed++;
        set_op(NPC_PC4);
        step();
        checks++; if (d_pc8 !== 32'h300A) $display("FAIL jr_next_d_pc8 got %h want %h", d_pc8, 32'h300A); else passed++;
        // Reserved encoding behaves as sequential fetch
        set_op(3'd6);
        step();
        checks++; if (f_pc !== 32'h300A) $display("FAIL rsvd_f_pc got %h want %h", f_pc, 32'h300A); else passed++;
        set_op(NPC_PC4);
    endtask

    task automatic test_wrap();
        set_op(NPC_JR); d_rs_val = 32'hFFFF_FFFC;
        step();
        checks++; if (f_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_setup_f_pc got %h want %h", f_pc, 32'hFFFF_FFFC); else passed++;
        set_op(NPC_PC4);
        step();
        checks++; if (f_pc !== 32'h0) $display("FAIL wrap_f_pc got %h want %h", f_pc, 32'h0); else passed++;
        checks++; if (d_pc8 !== 32'h4) $display("FAIL wrap_d_pc8 got %h want %h", d_pc8, 32'h4); else passed++;
    endtask

    task automatic test_stall_branch();
        restart();
        repeat (3) step();
        set_op(NPC_BRANCH); d_imm16 = 16'hFFFE; d_cmp_suc = 1'b1; stall = 1'b1;
        repeat (2) begin
            step();
            checks++; if (f_pc !== 32'h300C) $display("FAIL stall_f_pc got %h want %h", f_pc, 32'h300C); else passed++;
            checks++; if (d_pc !== 32'h3008) $display("FAIL stall_d_pc got %h want %h", d_pc, 32'h3008); else passed++;
            checks++; if (d_instr !== imw(32'h3008)) $display("FAIL stall_d_instr got %h want %h", d_instr, imw(32'h3008)); else passed++;
            checks++; if (fetch_cnt !== 32'd3) $display("FAIL stall_cnt got %0d want 3", fetch_cnt); else passed++;
        end
        stall = 1'b0;
        step();
        checks++; if (f_pc !== 32'h3004) $display("FAIL unstall_f_pc got %h want %h", f_pc, 32'h3004); else passed++;
        checks++; if (d_pc !== 32'h300C) $display("FAIL unstall_d_pc got %h want %h", d_pc, 32'h300C); else passed++;
        checks++; if (fetch_cnt !== 32'd4) $display("FAIL unstall_cnt got %0d want 4", fetch_cnt); else passed++;
        set_op(NPC_PC4);
    endtask

    task automatic test_async_reset();
        repeat (2) step();
        #2;
        reset = 1'b0;
        #1;
        checks++; if (f_pc !== 32'h3000) $display("FAIL areset_f_pc got %h want %h", f_pc, 32'h3000); else passed++;
        checks++; if (d_instr !== 32'h0) $display("FAIL areset_d_instr got %h want 0", d_instr); else passed++;
        checks++; if (d_pc !== 32'h0) $display("FAIL areset_d_pc got %h want 0", d_pc); else passed++;
        checks++; if (d_valid !== 1'b0) $display("FAIL areset_d_valid got %b want 0", d_valid); else passed++;
        checks++; if (fetch_cnt !== 32'h0) $display("FAIL areset_cnt got %h want 0", fetch_cnt); else passed++;
        #1;
        reset = 1'b1;
        step();
        checks++; if (f_pc !== 32'h3004) $display("FAIL areset_rel_f_pc got %h want %h", f_pc, 32'h3004); else passed++;
        checks++; if (fetch_cnt !== 32'd1) $display("FAIL areset_rel_cnt got %0d want 1", fetch_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jump();
        test_wrap();
        test_stall_branch();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
